// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronised serial line in, WIDTH-bit word out with valid strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_deserializer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             parity_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT >> 1) - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  logic             rx_meta_q, rx_s_q;
  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  bit_idx_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q, busy_q, ferr_q;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, perr_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= data_in_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_s_q) begin
            // The detection cycle itself counts as baud count 0.
            state_q <= StStart;
            cnt_q   <= CntW'(1);
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= StData;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[WIDTH-1:1]};
            bit_idx_q <= bit_idx_q + IdxW'(1);
            if (bit_idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == CntLast) begin
            cnt_q     <= '0;
            par_bad_q <= rx_s_q ^ (^shift_q);
            state_q   <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`endif
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                perr_q <= 1'b1;
              end else begin
                valid_q <= 1'b1;
                data_q  <= shift_q;
              end
`else
              valid_q <= 1'b1;
              data_q  <= shift_q;
`endif
            end else begin
              // Low stop bit: report once, then wait out any break condition.
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StBreak: begin
          if (rx_s_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_o  = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: the bench drives UART frames on data_in itself.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_deserializer;

  localparam int unsigned W    = 8;
  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB >> 1;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT = HALF + (W + 1) * CPB + CPB;
`else
  localparam int unsigned LAT = HALF + (W + 1) * CPB;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         data_in = 1'b1;
  logic [W-1:0] data_out;
  logic         valid, busy, frame_err, parity_err;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int vcnt = 0, fcnt = 0, pcnt = 0, overlap = 0, last_vcyc = 0;
  logic [W-1:0] vlog[$];

  uart_rx_deserializer #(
    .WIDTH        (W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_in_i    (data_in),
    .data_out_o   (data_out),
    .valid_o      (valid),
    .busy_o       (busy),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcnt <= vcnt + 1;
      vlog.push_back(data_out);
      last_vcyc <= cyc;
    end
    if (frame_err) fcnt <= fcnt + 1;
    if (parity_err) pcnt <= pcnt + 1;
    if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) overlap <= overlap + 1;
  end

  task automatic send_bit(input logic b);
    data_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < int'(W); i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) data_in = 1'b0;
`endif
    send_bit(stop);
  endtask

  task automatic test_reset;
    int v0;
    rst_n   = 1'b0;
    data_in = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out: got %h want 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    v0 = vcnt;
    repeat (200) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL idle_ferr: got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL idle_perr: got %b want 0", parity_err); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL idle_data_out: got %h want 00", data_out); end
    checks++; if (vcnt !== v0) begin errors++; $display("FAIL idle_valid_count: got %0d want %0d", vcnt, v0); end
  endtask

  task automatic test_single_frame;
    int n, v0, f0;
    n  = cyc;
    v0 = vcnt;
    f0 = fcnt;
    send_frame(8'h4C, 1'b1, ^8'h4C);
    repeat (4) @(negedge clk);
    checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL single_valid_count: got %0d want %0d", vcnt - v0, 1); end
    checks++; if (data_out !== 8'h4C) begin errors++; $display("FAIL single_data: got %h want 4c", data_out); end
    // data_in falls before posedge n+1; rx_s is low from cycle n+2 (t0).
    checks++; if (last_vcyc !== n + 2 + int'(LAT)) begin
      errors++; $display("FAIL single_latency: got cycle %0d want %0d", last_vcyc, n + 2 + int'(LAT));
    end
    checks++; if (fcnt !== f0) begin errors++; $display("FAIL single_ferr: got %0d want %0d", fcnt, f0); end
  endtask

  task automatic test_glitch;
    int v0, f0, p0;
    logic seen;
    v0 = vcnt; f0 = fcnt; p0 = pcnt;
    seen = 1'b0;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
    data_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got %b want 1", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    checks++; if ((vcnt - v0) + (fcnt - f0) + (pcnt - p0) !== 0) begin
      errors++; $display("FAIL glitch_pulses: got %0d want 0", (vcnt - v0) + (fcnt - f0) + (pcnt - p0));
    end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = vcnt; f0 = fcnt;
    send_frame(8'hA5, 1'b0, ^8'hA5);
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b want 1", busy); end
    data_in = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (fcnt !== f0 + 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fcnt - f0); end
    checks++; if (vcnt !== v0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", vcnt - v0); end
    checks++; if (data_out !== 8'h4C) begin errors++; $display("FAIL ferr_data_held: got %h want 4c", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_end: got %b want 0", busy); end
    send_frame(8'h3C, 1'b1, ^8'h3C);
    repeat (4) @(negedge clk);
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL after_ferr_data: got %h want 3c", data_out); end
    checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL after_ferr_valid: got %0d want 1", vcnt - v0); end
  endtask

  task automatic test_back_to_back;
    int v0, f0, p0;
    v0 = vcnt; f0 = fcnt; p0 = pcnt;
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    repeat (4) @(negedge clk);
    checks++; if (vcnt !== v0 + 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", vcnt - v0); end
    checks++; if (vlog.size() < v0 + 2 || vlog[v0] !== 8'h00) begin
      errors++; $display("FAIL b2b_first: got %h want 00", (vlog.size() > v0) ? vlog[v0] : 8'hxx);
    end
    checks++; if (vlog.size() < v0 + 2 || vlog[v0+1] !== 8'hFF) begin
      errors++; $display("FAIL b2b_second: got %h want ff", (vlog.size() > v0 + 1) ? vlog[v0+1] : 8'hxx);
    end
    checks++; if ((fcnt - f0) + (pcnt - p0) !== 0) begin
      errors++; $display("FAIL b2b_errs: got %0d want 0", (fcnt - f0) + (pcnt - p0));
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    logic [W-1:0] d;
    d  = 8'h5A;
    v0 = vcnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    data_in = d[4];
    repeat (HALF) @(negedge clk);
    rst_n   = 1'b0;
    data_in = 1'b1;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (vcnt !== v0) begin errors++; $display("FAIL midrst_no_valid: got %0d want 0", vcnt - v0); end
    send_frame(8'hC3, 1'b1, ^8'hC3);
    repeat (4) @(negedge clk);
    checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL midrst_next: got %h want c3", data_out); end
    checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL midrst_next_cnt: got %0d want 1", vcnt - v0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = vcnt; p0 = pcnt;
    send_frame(8'h01, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (pcnt !== p0 + 1) begin errors++; $display("FAIL par_bad_err: got %0d want 1", pcnt - p0); end
    checks++; if (vcnt !== v0) begin errors++; $display("FAIL par_bad_valid: got %0d want 0", vcnt - v0); end
    checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL par_bad_held: got %h want c3", data_out); end
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL par_good_valid: got %0d want 1", vcnt - v0); end
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL par_good_data: got %h want 01", data_out); end
    checks++; if (pcnt !== p0 + 1) begin errors++; $display("FAIL par_good_err: got %0d want 1", pcnt - p0); end
  endtask
`endif

  task automatic test_exclusive;
    checks++; if (overlap !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
